// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser followed by a confirm-counter
// debouncer for raw push-button / DIP pins. It produces a clean registered
// level and one-cycle fall/rise pulses that coincide with each level change.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN adds a hold counter and a
// one-cycle long_press pulse. Without the macro, long_press is tied to 0.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter logic        IDLE_LEVEL      = 1'b1,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_raw,
  output logic out,
  output logic fall,
  output logic rise,
  output logic long_press
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);

  typedef enum logic [0:0] {
    S_STABLE  = 1'b0,
    S_CONFIRM = 1'b1
  } state_t;

  logic                 s1_r;
  logic                 s2_r;
  state_t               state_r;
  state_t               state_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic                 out_r;
  logic                 out_s;
  logic                 fall_r;
  logic                 fall_s;
  logic                 rise_r;
  logic                 rise_s;

  // Two-flop synchroniser; only s2_r is consumed by the rest of the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= IDLE_LEVEL;
      s2_r <= IDLE_LEVEL;
    end else begin
      s1_r <= in_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce state, confirm counter and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_STABLE;
      cnt_r   <= {CNT_WIDTH{1'b0}};
      out_r   <= IDLE_LEVEL;
      fall_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      fall_r  <= fall_s;
      rise_r  <= rise_s;
    end
  end

  // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES+1
  // consecutive diverging samples; any agreeing sample discards the count.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    fall_s  = 1'b0;
    rise_s  = 1'b0;
    case (state_r)
      S_STABLE: begin
        if (s2_r != out_r) begin
          state_s = S_CONFIRM;
          cnt_s   = CNT_WIDTH'(1'b1);
        end else begin
          cnt_s   = {CNT_WIDTH{1'b0}};
        end
      end
      S_CONFIRM: begin
        if (s2_r == out_r) begin
          state_s = S_STABLE;
          cnt_s   = {CNT_WIDTH{1'b0}};
        end else if (cnt_r < CNT_MAX) begin
          cnt_s   = cnt_r + CNT_WIDTH'(1'b1);
        end else begin
          state_s = S_STABLE;
          cnt_s   = {CNT_WIDTH{1'b0}};
          out_s   = s2_r;
          fall_s  = (s2_r == 1'b0);
          rise_s  = (s2_r == 1'b1);
        end
      end
      default: begin
        state_s = S_STABLE;
        cnt_s   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  assign out  = out_r;
  assign fall = fall_r;
  assign rise = rise_r;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int LCNT_WIDTH = $clog2(LONG_CYCLES + 1);
  localparam logic [LCNT_WIDTH-1:0] LCNT_MAX = LCNT_WIDTH'(LONG_CYCLES);

  logic [LCNT_WIDTH-1:0] hcnt_r;
  logic                  long_r;

  // Hold counter: runs while the clean level is non-idle, saturates at
  // LONG_CYCLES and pulses long_press once on reaching it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= {LCNT_WIDTH{1'b0}};
      long_r <= 1'b0;
    end else if (out_r == IDLE_LEVEL) begin
      hcnt_r <= {LCNT_WIDTH{1'b0}};
      long_r <= 1'b0;
    end else if (hcnt_r < LCNT_MAX) begin
      hcnt_r <= hcnt_r + LCNT_WIDTH'(1'b1);
      long_r <= (hcnt_r == (LCNT_MAX - LCNT_WIDTH'(1'b1)));
    end else begin
      long_r <= 1'b0;
    end
  end

  assign long_press = long_r;
`else
  assign long_press = 1'b0;
`endif

endmodule
